ofs_plat_axi_stream_if_buffer: RTL and testbench

Parametrised, registered, elastic connection between one AXI stream source and one sink. It replaces the purely combinational wire-through connection wherever timing isolation or buffering is required. A DEPTH-entry FIFO breaks every forward (tvalid/tdata/tlast/tuser) and backward (tready) path, with full throughput. It adds occupancy, almost-full and complete-packet status outputs for flow-control and arbitration logic.

---
 rtl/ofs_plat_axi_stream_buf_pkg.sv | 38 +++
 rtl/ofs_plat_axi_stream_buf_ram.sv | 38 +++
 rtl/ofs_plat_axi_stream_if_buffer.sv | 171 +++++++++++++++++
 tb/tb_ofs_plat_axi_stream_if_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_plat_axi_stream_buf_pkg.sv
// Shared types and width helpers for the registered AXI stream buffer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: beat struct macro {tuser, tlast, tkeep, tdata}; count/pointer/beat width helpers.

`ifndef OFS_PLAT_AXI_STREAM_BUF_PKG_SV
`define OFS_PLAT_AXI_STREAM_BUF_PKG_SV

// A package cannot carry a typedef parameterised by a module's widths, so the
// beat layout is provided as a macro and expanded inside each user module.
`define OFS_PLAT_AXIS_BEAT_T(DW, UW) \
   struct packed { \
      logic [(UW)-1:0]   tuser; \
      logic              tlast; \
      logic [(DW)/8-1:0] tkeep; \
      logic [(DW)-1:0]   tdata; \
   }

package ofs_plat_axi_stream_buf_pkg;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a pointer into a depth-entry array (at least one bit).
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Packed width of one beat: tuser + tlast + tkeep + tdata.
   function automatic int beat_width(input int dw, input int uw);
      return uw + 1 + dw / 8 + dw;
   endfunction

endpackage

`endif

// File: rtl/ofs_plat_axi_stream_buf_ram.sv
// Simple dual-port beat storage: one synchronous write port, one registered read port.
// Latency: rdata_o reflects raddr_i one clock after it is presented.
// Backpressure: none; the owner guarantees it never overwrites an unread entry.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i read address; rdata_o registered read data.

module ofs_plat_axi_stream_buf_ram #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write-first on an address collision: the owner reads the slot it is
   // writing in the same cycle whenever the storage is about to hold exactly
   // that one beat at its head, and must see the new value a cycle later.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (we_i && (waddr_i == raddr_i)) begin
         rdata_q <= wdata_i;
      end else begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ofs_plat_axi_stream_if_buffer.sv
// Registered elastic AXI stream buffer (DEPTH beats) with occupancy/packet status.
// Latency: 1 cycle push-to-visible; 1 beat/cycle sustained; all outputs registered.
// Backpressure: src_tready is registered (count_next < DEPTH); a full buffer loses one input cycle after a pop.
// Ports: clk, reset_n (async, active-low); src_* AXI-S slave; snk_* AXI-S master;
//        count (held beats), almost_full (count >= ALMOST_FULL_THRESH), pkt_count (held beats with tlast).

module ofs_plat_axi_stream_if_buffer
   import ofs_plat_axi_stream_buf_pkg::*;
#(
   parameter int DATA_WIDTH         = 512,
   parameter int USER_WIDTH         = 1,
   parameter int DEPTH              = 4,
   parameter int ALMOST_FULL_THRESH = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       reset_n,

   input  logic                       src_tvalid,
   output logic                       src_tready,
   input  logic [DATA_WIDTH-1:0]      src_tdata,
   input  logic [DATA_WIDTH/8-1:0]    src_tkeep,
   input  logic                       src_tlast,
   input  logic [USER_WIDTH-1:0]      src_tuser,

   output logic                       snk_tvalid,
   input  logic                       snk_tready,
   output logic [DATA_WIDTH-1:0]      snk_tdata,
   output logic [DATA_WIDTH/8-1:0]    snk_tkeep,
   output logic                       snk_tlast,
   output logic [USER_WIDTH-1:0]      snk_tuser,

   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam int BW = beat_width(DATA_WIDTH, USER_WIDTH);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESH);

   typedef `OFS_PLAT_AXIS_BEAT_T(DATA_WIDTH, USER_WIDTH) beat_t;

   beat_t          src_beat;
   beat_t          ram_rdata;
   logic [BW-1:0]  ram_rdata_raw;

   beat_t          head_q,     head_d;
   logic           head_vld_q, head_vld_d;
   logic [PW-1:0]  wr_ptr_q,   wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]  count_q,    count_d;
   logic [CW-1:0]  pkt_q,      pkt_d;
   logic           src_rdy_q,  src_rdy_d;
   logic           af_q,       af_d;

   logic           push;
   logic           pop;
   logic           head_load;
   logic [CW-1:0]  st_cnt;
   logic           st_empty;
   logic           ram_we;

   assign src_beat  = {src_tuser, src_tlast, src_tkeep, src_tdata};
   assign ram_rdata = beat_t'(ram_rdata_raw);

   // The head register carries the oldest beat; the RAM holds everything
   // behind it. The RAM is always reading the slot that will be the next head
   // (rd_ptr_d), so its registered output is ready the moment the head drains.
   always_comb begin
      push       = src_tvalid & src_rdy_q;
      pop        = head_vld_q & snk_tready;
      st_cnt     = count_q - CW'(head_vld_q);
      st_empty   = (st_cnt == '0);
      head_load  = pop | ~head_vld_q;

      head_d     = head_q;
      head_vld_d = head_vld_q;
      rd_ptr_d   = rd_ptr_q;
      ram_we     = push;

      if (head_load) begin
         if (!st_empty) begin
            head_d     = ram_rdata;
            head_vld_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PW'(1);
         end else if (push) begin
            // Nothing stored behind the head: the new beat goes straight
            // into the head and never touches the RAM.
            head_d     = src_beat;
            head_vld_d = 1'b1;
            ram_we     = 1'b0;
         end else begin
            head_vld_d = 1'b0;
         end
      end

      wr_ptr_d  = wr_ptr_q + PW'(ram_we);
      count_d   = count_q + CW'(push) - CW'(pop);
      pkt_d     = pkt_q + CW'(push & src_tlast) - CW'(pop & head_q.tlast);
      src_rdy_d = (count_d < DEPTH_C);
      af_d      = (count_d >= AF_C);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q     <= '0;
         head_vld_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pkt_q      <= '0;
         src_rdy_q  <= 1'b0;
         af_q       <= 1'b0;
      end else begin
         head_q     <= head_d;
         head_vld_q <= head_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pkt_q      <= pkt_d;
         src_rdy_q  <= src_rdy_d;
         af_q       <= af_d;
      end
   end

   ofs_plat_axi_stream_buf_ram #(
      .DEPTH (DEPTH),
      .WIDTH (BW),
      .AW    (PW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (src_beat),
      .raddr_i (rd_ptr_d),
      .rdata_o (ram_rdata_raw)
   );

   assign src_tready  = src_rdy_q;
   assign snk_tvalid  = head_vld_q;
   assign snk_tdata   = head_q.tdata;
   assign snk_tkeep   = head_q.tkeep;
   assign snk_tlast   = head_q.tlast;
   assign snk_tuser   = head_q.tuser;
   assign count       = count_q;
   assign almost_full = af_q;
   assign pkt_count   = pkt_q;

`ifndef SYNTHESIS
   localparam bit PARAM_OK = (DATA_WIDTH > 0) && ((DATA_WIDTH % 8) == 0) &&
                             (USER_WIDTH >= 1) && (DEPTH >= 2) &&
                             ((DEPTH & (DEPTH - 1)) == 0) &&
                             (ALMOST_FULL_THRESH >= 1) && (ALMOST_FULL_THRESH <= DEPTH);

   a_param_ok: assert property (@(posedge clk) PARAM_OK)
      else $error("illegal parameter combination");
   a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && (count_q == DEPTH_C)))
      else $error("push while full");
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
      !(pop && (count_q == '0)))
      else $error("pop while empty");
   a_pkt_le_count: assert property (@(posedge clk) disable iff (!reset_n)
      (pkt_q <= count_q))
      else $error("pkt_count exceeds count");
`endif

endmodule

// File: tb/tb_ofs_plat_axi_stream_if_buffer.sv
module tb_ofs_plat_axi_stream_if_buffer;

   localparam int DW    = 32;
   localparam int UW    = 4;
   localparam int DEPTH = 4;
   localparam int AFT   = 3;
   localparam int CW    = 3;
   localparam int BW    = UW + 1 + DW / 8 + DW;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            src_tvalid;
   logic            src_tready;
   logic [DW-1:0]   src_tdata;
   logic [DW/8-1:0] src_tkeep;
   logic            src_tlast;
   logic [UW-1:0]   src_tuser;
   logic            snk_tvalid;
   logic            snk_tready;
   logic [DW-1:0]   snk_tdata;
   logic [DW/8-1:0] snk_tkeep;
   logic            snk_tlast;
   logic [UW-1:0]   snk_tuser;
   logic [CW-1:0]   count;
   logic            almost_full;
   logic [CW-1:0]   pkt_count;

   ofs_plat_axi_stream_if_buffer #(
      .DATA_WIDTH         (DW),
      .USER_WIDTH         (UW),
      .DEPTH              (DEPTH),
      .ALMOST_FULL_THRESH (AFT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .src_tvalid  (src_tvalid),
      .src_tready  (src_tready),
      .src_tdata   (src_tdata),
      .src_tkeep   (src_tkeep),
      .src_tlast   (src_tlast),
      .src_tuser   (src_tuser),
      .snk_tvalid  (snk_tvalid),
      .snk_tready  (snk_tready),
      .snk_tdata   (snk_tdata),
      .snk_tkeep   (snk_tkeep),
      .snk_tlast   (snk_tlast),
      .snk_tuser   (snk_tuser),
      .count       (count),
      .almost_full (almost_full),
      .pkt_count   (pkt_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard and reference model of occupancy / status.
   logic [BW-1:0] sb [$];
   int            cnt_m = 0;
   int            pk_m  = 0;
   logic          rdy_m = 1'b0;
   logic          af_m  = 1'b0;
   int            pops  = 0;
   int            both_last = 0;
   logic          p_push, p_pop;
   logic [BW-1:0] exp_b;
   logic          ph4_done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, compares status against the model,
   // pops the scoreboard on every sink handshake, then advances the model to
   // the state expected after the next rising edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_src_tready", src_tready, 0);
         chk("rst_snk_tvalid", snk_tvalid, 0);
         chk("rst_count", count, 0);
         chk("rst_almost_full", almost_full, 0);
         chk("rst_pkt_count", pkt_count, 0);
         cnt_m = 0; pk_m = 0; rdy_m = 1'b0; af_m = 1'b0;
         sb.delete();
      end else begin
         chk("src_tready", src_tready, rdy_m);
         chk("snk_tvalid", snk_tvalid, (cnt_m != 0));
         chk("count", count, cnt_m);
         chk("almost_full", almost_full, af_m);
         chk("pkt_count", pkt_count, pk_m);
         p_push = src_tvalid && src_tready;
         p_pop  = snk_tvalid && snk_tready;
         if (p_pop) begin
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL pop_unexpected: got beat %0h expected none at %0t",
                        {snk_tuser, snk_tlast, snk_tkeep, snk_tdata}, $time);
            end else begin
               exp_b = sb.pop_front();
               chk("beat", {snk_tuser, snk_tlast, snk_tkeep, snk_tdata}, exp_b);
               pops++;
            end
         end
         if (p_push) sb.push_back({src_tuser, src_tlast, src_tkeep, src_tdata});
         if (p_push && src_tlast && p_pop && snk_tlast) both_last++;
         cnt_m = cnt_m + int'(p_push) - int'(p_pop);
         pk_m  = pk_m + int'(p_push && src_tlast) - int'(p_pop && snk_tlast);
         rdy_m = (cnt_m < DEPTH);
         af_m  = (cnt_m >= AFT);
      end
   end

   // Presents one beat (call at posedge+1); returns at posedge+1 after it is taken.
   task automatic send(input logic [DW-1:0] d, input logic [DW/8-1:0] k,
                       input logic l, input logic [UW-1:0] u);
      int  t;
      bit  done;
      t = 0; done = 0;
      src_tdata = d; src_tkeep = k; src_tlast = l; src_tuser = u; src_tvalid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (src_tready) begin
            @(posedge clk); #1;
            done = 1;
         end else begin
            t++;
            if (t > 200) begin
               n_cmp++; n_err++;
               $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
               done = 1;
            end
         end
      end
      src_tvalid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      time t0;
      int  p0, b0;
      reset_n = 1'b0; src_tvalid = 1'b0; snk_tready = 1'b0;
      src_tdata = '0; src_tkeep = '0; src_tlast = 1'b0; src_tuser = '0;
      ph4_done = 1'b0;

      // Reset release.
      repeat (3) @(posedge clk);
      #1;
      chk("tready_in_reset", src_tready, 0);
      reset_n = 1'b1;
      #1 chk("tready_at_release", src_tready, 0);
      @(posedge clk); #1;
      chk("tready_after_release", src_tready, 1);
      chk("count_after_release", count, 0);
      chk("snk_tvalid_after_release", snk_tvalid, 0);

      // Fill to full with the sink stalled.
      for (int i = 0; i < 4; i++) begin
         send(32'hA0 + i, 4'hF, 1'b0, 4'(i));
         chk("fill_count", count, i + 1);
         chk("fill_almost_full", almost_full, (i + 1 >= 3));
      end
      chk("full_tready", src_tready, 0);
      chk("full_head", snk_tdata, 32'hA0);
      // Fifth beat waits at the source.
      src_tdata = 32'hA4; src_tkeep = 4'hF; src_tlast = 1'b0; src_tuser = 4'd4; src_tvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("held_count", count, 4);
      snk_tready = 1'b1;
      @(posedge clk); #1;
      snk_tready = 1'b0;
      chk("rdy_after_pop", src_tready, 1);
      chk("count_after_pop", count, 3);
      @(posedge clk); #1;
      src_tvalid = 1'b0;
      chk("count_back_full", count, 4);
      snk_tready = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("drained_1", count, 0);

      // 100-beat back-to-back stream.
      p0 = pops; t0 = $time;
      for (int i = 0; i < 100; i++) begin
         send(32'h100 + i, 4'hF, 1'b0, 4'(i));
         chk("stream_count", count, 1);
      end
      chk("stream_cycles", ($time - t0) / 10, 100);
      repeat (2) @(posedge clk);
      #1 chk("stream_pops", pops - p0, 100);

      // 3-beat packets with a random sink.
      fork
         begin
            for (int p = 0; p < 6; p++)
               for (int b = 0; b < 3; b++)
                  send(32'hC000_0000 | (p << 8) | b, 4'hF >> b, (b == 2), 4'(b));
            ph4_done = 1'b1;
         end
         begin
            while (!ph4_done) begin
               @(posedge clk); #1;
               snk_tready = 1'($urandom_range(0, 1));
            end
         end
      join
      snk_tready = 1'b1;
      repeat (8) @(posedge clk);
      #1 chk("drained_2", count, 0);
      chk("drained_2_pkt", pkt_count, 0);

      // Single-beat packets: tlast pushed and popped on the same edge.
      b0 = both_last;
      for (int i = 0; i < 8; i++) send(32'hD0 + i, 4'h3, 1'b1, 4'(i));
      chk("pkt_count_steady", pkt_count, 1);
      repeat (3) @(posedge clk);
      #1 chk("tlast_push_pop_seen", (both_last > b0), 1);

      // Reset in the middle of a packet.
      snk_tready = 1'b0;
      send(32'hE0, 4'hF, 1'b0, 4'd0);
      send(32'hE1, 4'hF, 1'b0, 4'd1);
      chk("pre_reset_count", count, 2);
      #1 reset_n = 1'b0;
      #1;
      chk("async_snk_tvalid", snk_tvalid, 0);
      chk("async_count", count, 0);
      chk("async_pkt_count", pkt_count, 0);
      chk("async_tready", src_tready, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      snk_tready = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("no_stale", snk_tvalid, 0);
      p0 = pops;
      send(32'hF0, 4'h1, 1'b1, 4'd7);
      repeat (3) @(posedge clk);
      #1 chk("post_reset_pop", pops - p0, 1);
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
